pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
Central sequencing controller for the 5-stage ARM pipeline. It sits beside the EXE and MEM stages and decides every cycle whether the pipeline advances, stalls or flushes. It has three jobs:
- Detect load-use and RAW hazards from the ID-stage sources against the EXE/MEM destinations.
- Flush the front end when the EXE stage resolves a taken branch.
- Run a request/ready handshake FSM that freezes the whole pipeline while a MEM-stage load/store waits on SRAM.

Parameters:
FWD_EN, 1, 1 = forwarding unit present, so only EXE-stage loads cause a stall; 0 = any EXE/MEM writeback to a matching register stalls.
TIMEOUT, 16, maximum SRAM wait cycles before the access is forcibly completed and an error is flagged (≥2).
CNT_W, 32, width of the stall performance counter.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
id_valid  in  1  ID stage holds a real instruction
id_src1  in  4  Rn index in ID
id_src2  in  4  Rm/Rd index in ID
id_two_src  in  1  src2 is actually read
exe_wb_en  in  1  EXE instruction writes back
exe_mem_r_en  in  1  EXE instruction is a load
exe_dest  in  4  EXE destination register
exe_branch_taken  in  1  EXE resolves a taken branch this cycle
mem_wb_en  in  1  MEM instruction writes back
mem_dest  in  4  MEM destination register
mem_r_en  in  1  MEM instruction is a load
mem_w_en  in  1  MEM instruction is a store
sram_ready  in  1  SRAM finished the current access
sram_req  out  1  SRAM access request, registered
sram_we  out  1  write strobe qualifying sram_req, registered
freeze_all  out  1  hold every pipeline register, including PC
freeze_fd  out  1  hold PC and the IF/ID register
flush_fd  out  1  clear the IF/ID register
bubble_de  out  1  load a NOP into the ID/EXE register
mem_err  out  1  sticky flag: an access timed out
stall_cnt  out  CNT_W  cycles in which freeze_fd or freeze_all was high

Behaviour:
Reset (rst=0, asynchronous):
- FSM goes to IDLE.
- sram_req=0, sram_we=0, mem_err=0, stall_cnt=0, wait counter=0.
- The same applies if reset asserts mid-access; a pending sram_ready after reset is ignored.

Memory FSM, states IDLE, ACCESS, DONE:
- IDLE: if mem_r_en|mem_w_en, go to ACCESS next edge, registering sram_req=1 and sram_we=mem_w_en.
- ACCESS: wait counter increments each cycle.
  - sram_ready=1: go to DONE and clear sram_req.
  - Otherwise, when the counter reaches TIMEOUT-1: go to DONE, clear sram_req, set mem_err=1.
  - sram_ready and timeout in the same cycle: normal completion, mem_err not set.
- DONE: go to IDLE unconditionally; the wait counter clears.
  - DONE guarantees one advancing cycle, so the same MEM instruction is never re-issued.
  - Back-to-back memory ops therefore cost one DONE cycle plus the IDLE detect cycle each.

freeze_all (combinational):
- 1 in IDLE while mem_r_en|mem_w_en.
- 1 throughout ACCESS.
- 0 in DONE.
- Net effect: a 1-cycle ready gives 2 frozen cycles.

Hazard (combinational):
- match1 = id_src1 equal to the destination under test.
- match2 = id_two_src & id_src2 equal to the destination under test.
- FWD_EN=1: hazard = id_valid & exe_wb_en & exe_mem_r_en & (match1|match2 on exe_dest).
- FWD_EN=0: hazard = id_valid & ((exe_wb_en & match on exe_dest) | (mem_wb_en & match on mem_dest)).

Output priority, combinational, highest first:
1. freeze_all=1 → freeze_fd=0, flush_fd=0, bubble_de=0. A branch or hazard is held and re-evaluated once the freeze drops.
2. exe_branch_taken → flush_fd=1, bubble_de=1, freeze_fd=0. The hazard is ignored.
3. hazard → freeze_fd=1, bubble_de=1.
4. Otherwise all outputs 0.

Counters and flags:
- stall_cnt increments on every edge where freeze_all|freeze_fd is high.
- stall_cnt saturates at all-ones and does not wrap.
- mem_err clears only on reset.

Decomposition:
- Shared package (arm_pkg): mem FSM state enum (IDLE, ACCESS, DONE), 4-bit register index type, NOP control constants.
- Natural sub-module: hazard_unit, purely combinational; FWD_EN is passed down to it.
- The FSM, priority logic and counters live in pipe_ctrl.

Test Plan:
1. Load-use: exe_wb_en=1, exe_mem_r_en=1, exe_dest=3, id_src1=3, id_valid=1, FWD_EN=1 → freeze_fd=1, bubble_de=1; same with exe_mem_r_en=0 → all outputs 0.
2. No-forward RAW: FWD_EN=0, mem_wb_en=1, mem_dest=5, id_two_src=1, id_src2=5 → freeze_fd=1; same with id_two_src=0 → no stall.
3. Load with sram_ready high 3 cycles after sram_req rises:
   - freeze_all high 4 cycles (IDLE detect + 3 ACCESS), then low for 1 DONE cycle.
   - sram_we=0; stall_cnt=4.
4. Store that never gets sram_ready, TIMEOUT=16:
   - sram_req high exactly 16 cycles, sram_we=1.
   - mem_err=1 and stays 1 until rst=0.
5. Branch during a memory freeze: exe_branch_taken=1 while in ACCESS → flush_fd=0; flush_fd=1 and bubble_de=1 in the DONE cycle. Branch plus hazard together → flush_fd=1, freeze_fd=0.
6. rst=0 pulsed mid-ACCESS → sram_req=0 and FSM in IDLE immediately; stall_cnt=0; sram_ready after release causes no transition.

Source files
------------

// File: rtl/arm_pkg.sv
// Shared types for the ARM pipeline control slice:
// memory FSM states, register index type, front-end control codes.
package arm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } mem_state_e;

  typedef logic [3:0] reg_idx_t;

  typedef struct packed {
    logic freeze_fd;
    logic flush_fd;
    logic bubble_de;
  } fe_ctrl_t;

  localparam fe_ctrl_t CTRL_NOP   = '{
    freeze_fd: 1'b0,
    flush_fd:  1'b0,
    bubble_de: 1'b0
  };
  localparam fe_ctrl_t CTRL_FLUSH = '{
    freeze_fd: 1'b0,
    flush_fd:  1'b1,
    bubble_de: 1'b1
  };
  localparam fe_ctrl_t CTRL_STALL = '{
    freeze_fd: 1'b1,
    flush_fd:  1'b0,
    bubble_de: 1'b1
  };

  function automatic logic src_match(
    input reg_idx_t src,
    input logic     rd,
    input reg_idx_t dest
  );
    return rd && (src == dest);
  endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_unit.sv
// Combinational RAW / load-use detector: ID sources vs EXE/MEM dests.
// In: ID srcs, EXE/MEM writeback info. Out: hazard.
module hazard_unit
  import arm_pkg::*;
#(
  parameter bit FWD_EN = 1'b1
) (
  input  logic     id_valid,
  input  reg_idx_t id_src1,
  input  reg_idx_t id_src2,
  input  logic     id_two_src,
  input  logic     exe_wb_en,
  input  logic     exe_mem_r_en,
  input  reg_idx_t exe_dest,
  input  logic     mem_wb_en,
  input  reg_idx_t mem_dest,
  output logic     hazard
);

  logic exe_hit;
  logic mem_hit;
  logic hz_fwd;
  logic hz_nofwd;

  assign exe_hit =
    src_match(id_src1, 1'b1, exe_dest) |
    src_match(id_src2, id_two_src, exe_dest);

  assign mem_hit =
    src_match(id_src1, 1'b1, mem_dest) |
    src_match(id_src2, id_two_src, mem_dest);

  // With forwarding only a load still in EXE
  // cannot supply its result in time.
  assign hz_fwd = id_valid & exe_wb_en &
                  exe_mem_r_en & exe_hit;

  assign hz_nofwd = id_valid & (
                      (exe_wb_en & exe_hit) |
                      (mem_wb_en & mem_hit));

  assign hazard = FWD_EN ? hz_fwd : hz_nofwd;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing: hazard stall, branch flush, SRAM wait freeze.
// Out: sram_req/we, freeze/flush/bubble controls, mem_err, stall_cnt.
module pipe_ctrl
  import arm_pkg::*;
#(
  parameter bit          FWD_EN  = 1'b1,
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [3:0]       id_src1,
  input  logic [3:0]       id_src2,
  input  logic             id_two_src,
  input  logic             exe_wb_en,
  input  logic             exe_mem_r_en,
  input  logic [3:0]       exe_dest,
  input  logic             exe_branch_taken,
  input  logic             mem_wb_en,
  input  logic [3:0]       mem_dest,
  input  logic             mem_r_en,
  input  logic             mem_w_en,
  input  logic             sram_ready,
  output logic             sram_req,
  output logic             sram_we,
  output logic             freeze_all,
  output logic             freeze_fd,
  output logic             flush_fd,
  output logic             bubble_de,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int unsigned WAIT_W =
    (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST =
    WAIT_W'(TIMEOUT - 1);

  mem_state_e        state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              mem_op;
  logic              hazard;
  logic              take_branch;
  logic              take_stall;
  fe_ctrl_t          ctrl;

  assign mem_op = mem_r_en | mem_w_en;

  hazard_unit #(
    .FWD_EN(FWD_EN)
  ) u_hazard (
    .id_valid     (id_valid),
    .id_src1      (id_src1),
    .id_src2      (id_src2),
    .id_two_src   (id_two_src),
    .exe_wb_en    (exe_wb_en),
    .exe_mem_r_en (exe_mem_r_en),
    .exe_dest     (exe_dest),
    .mem_wb_en    (mem_wb_en),
    .mem_dest     (mem_dest),
    .hazard       (hazard)
  );

  // Memory handshake FSM; req/we are registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      sram_req <= 1'b0;
      sram_we  <= 1'b0;
      mem_err  <= 1'b0;
      wait_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          wait_cnt <= '0;
          if (mem_op) begin
            state    <= ACCESS;
            sram_req <= 1'b1;
            sram_we  <= mem_w_en;
          end
        end
        ACCESS: begin
          wait_cnt <= wait_cnt + WAIT_W'(1);
          // Ready wins over a simultaneous timeout.
          if (sram_ready) begin
            state    <= DONE;
            sram_req <= 1'b0;
            sram_we  <= 1'b0;
          end else if (wait_cnt == WAIT_LAST) begin
            state    <= DONE;
            sram_req <= 1'b0;
            sram_we  <= 1'b0;
            mem_err  <= 1'b1;
          end
        end
        DONE: begin
          // One advancing cycle so the op is not re-issued.
          state    <= IDLE;
          wait_cnt <= '0;
        end
        default: begin
          state    <= IDLE;
          sram_req <= 1'b0;
          sram_we  <= 1'b0;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  always_comb begin
    freeze_all = 1'b0;
    unique case (state)
      IDLE:    freeze_all = mem_op;
      ACCESS:  freeze_all = 1'b1;
      DONE:    freeze_all = 1'b0;
      default: freeze_all = 1'b0;
    endcase
  end

  // A freeze masks branch and hazard; they are
  // re-evaluated once the freeze drops.
  assign take_branch = ~freeze_all & exe_branch_taken;
  assign take_stall  = ~freeze_all & ~exe_branch_taken
                       & hazard;

  always_comb begin
    ctrl = CTRL_NOP;
    unique case (1'b1)
      take_branch: ctrl = CTRL_FLUSH;
      take_stall:  ctrl = CTRL_STALL;
      default:     ctrl = CTRL_NOP;
    endcase
  end

  assign freeze_fd = ctrl.freeze_fd;
  assign flush_fd  = ctrl.flush_fd;
  assign bubble_de = ctrl.bubble_de;

  // Saturating stall counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if ((freeze_all | freeze_fd) &&
                 (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed testbench for pipe_ctrl.
// Two instances: forwarding (main) and no-forward with 3-bit counter.
module tb_pipe_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [3:0] id_src1;
  logic [3:0] id_src2;
  logic       id_two_src;
  logic       exe_wb_en;
  logic       exe_mem_r_en;
  logic [3:0] exe_dest;
  logic       exe_branch_taken;
  logic       mem_wb_en;
  logic [3:0] mem_dest;
  logic       mem_r_en;
  logic       mem_w_en;
  logic       sram_ready;

  logic        sram_req, sram_we, freeze_all;
  logic        freeze_fd, flush_fd, bubble_de, mem_err;
  logic [31:0] stall_cnt;

  logic       nf_sram_req, nf_sram_we, nf_freeze_all;
  logic       nf_freeze_fd, nf_flush_fd, nf_bubble_de;
  logic       nf_mem_err;
  logic [2:0] nf_stall_cnt;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(
    .FWD_EN(1'b1), .TIMEOUT(16), .CNT_W(32)
  ) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_src1(id_src1),
    .id_src2(id_src2), .id_two_src(id_two_src),
    .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
    .exe_dest(exe_dest),
    .exe_branch_taken(exe_branch_taken),
    .mem_wb_en(mem_wb_en), .mem_dest(mem_dest),
    .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .sram_ready(sram_ready),
    .sram_req(sram_req), .sram_we(sram_we),
    .freeze_all(freeze_all), .freeze_fd(freeze_fd),
    .flush_fd(flush_fd), .bubble_de(bubble_de),
    .mem_err(mem_err), .stall_cnt(stall_cnt)
  );

  pipe_ctrl #(
    .FWD_EN(1'b0), .TIMEOUT(16), .CNT_W(3)
  ) dut_nf (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_src1(id_src1),
    .id_src2(id_src2), .id_two_src(id_two_src),
    .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
    .exe_dest(exe_dest),
    .exe_branch_taken(exe_branch_taken),
    .mem_wb_en(mem_wb_en), .mem_dest(mem_dest),
    .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .sram_ready(sram_ready),
    .sram_req(nf_sram_req), .sram_we(nf_sram_we),
    .freeze_all(nf_freeze_all), .freeze_fd(nf_freeze_fd),
    .flush_fd(nf_flush_fd), .bubble_de(nf_bubble_de),
    .mem_err(nf_mem_err), .stall_cnt(nf_stall_cnt)
  );

  task automatic clear_inputs;
    id_valid         = 1'b0;
    id_src1          = 4'd0;
    id_src2          = 4'd0;
    id_two_src       = 1'b0;
    exe_wb_en        = 1'b0;
    exe_mem_r_en     = 1'b0;
    exe_dest         = 4'd0;
    exe_branch_taken = 1'b0;
    mem_wb_en        = 1'b0;
    mem_dest         = 4'd0;
    mem_r_en         = 1'b0;
    mem_w_en         = 1'b0;
    sram_ready       = 1'b0;
  endtask

  task automatic apply_reset;
    @(negedge clk);
    clear_inputs();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset;
    clear_inputs();
    rst = 1'b0;
    #2;
    vecs++;
    if ({sram_req, sram_we, mem_err, freeze_all} !== 4'b0000)
      $display("FAIL reset_flags: got %b expected 0000",
               {sram_req, sram_we, mem_err, freeze_all});
    vecs++;
    if (stall_cnt !== 32'd0) begin
      errs++;
      $display("FAIL reset_cnt: got %0d expected 0", stall_cnt);
    end
    if ({sram_req, sram_we, mem_err, freeze_all} !== 4'b0000)
      errs++;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_load_use;
    @(negedge clk);
    id_valid = 1'b1; id_src1 = 4'd3;
    exe_wb_en = 1'b1; exe_mem_r_en = 1'b1; exe_dest = 4'd3;
    #1;
    vecs++;
    if ({freeze_fd, flush_fd, bubble_de} !== 3'b101) begin
      errs++;
      $display("FAIL load_use: got %b expected 101",
               {freeze_fd, flush_fd, bubble_de});
    end
    exe_mem_r_en = 1'b0;
    #1;
    vecs++;
    if ({freeze_fd, flush_fd, bubble_de} !== 3'b000) begin
      errs++;
      $display("FAIL no_load_fwd: got %b expected 000",
               {freeze_fd, flush_fd, bubble_de});
    end
    vecs++;
    if (nf_freeze_fd !== 1'b1) begin
      errs++;
      $display("FAIL exe_raw_nofwd: got %b expected 1",
               nf_freeze_fd);
    end
    id_src1 = 4'd4; id_src2 = 4'd3; id_two_src = 1'b0;
    #1;
    vecs++;
    if (nf_freeze_fd !== 1'b0) begin
      errs++;
      $display("FAIL src2_unread: got %b expected 0",
               nf_freeze_fd);
    end
    clear_inputs();
  endtask

  task automatic test_raw_nofwd;
    @(negedge clk);
    id_valid = 1'b1; id_src1 = 4'd0;
    mem_wb_en = 1'b1; mem_dest = 4'd5;
    id_two_src = 1'b1; id_src2 = 4'd5;
    #1;
    vecs++;
    if ({nf_freeze_fd, nf_flush_fd, nf_bubble_de} !== 3'b101)
    begin
      errs++;
      $display("FAIL mem_raw: got %b expected 101",
               {nf_freeze_fd, nf_flush_fd, nf_bubble_de});
    end
    vecs++;
    if (freeze_fd !== 1'b0) begin
      errs++;
      $display("FAIL mem_raw_fwd: got %b expected 0",
               freeze_fd);
    end
    id_two_src = 1'b0;
    #1;
    vecs++;
    if ({nf_freeze_fd, nf_bubble_de} !== 2'b00) begin
      errs++;
      $display("FAIL mem_raw_one_src: got %b expected 00",
               {nf_freeze_fd, nf_bubble_de});
    end
    id_two_src = 1'b1; id_valid = 1'b0;
    #1;
    vecs++;
    if (nf_freeze_fd !== 1'b0) begin
      errs++;
      $display("FAIL id_invalid: got %b expected 0",
               nf_freeze_fd);
    end
    clear_inputs();
  endtask

  task automatic test_branch_hazard;
    @(negedge clk);
    id_valid = 1'b1; id_src1 = 4'd3;
    exe_wb_en = 1'b1; exe_mem_r_en = 1'b1; exe_dest = 4'd3;
    exe_branch_taken = 1'b1;
    #1;
    vecs++;
    if ({freeze_fd, flush_fd, bubble_de} !== 3'b011) begin
      errs++;
      $display("FAIL branch_hazard: got %b expected 011",
               {freeze_fd, flush_fd, bubble_de});
    end
    clear_inputs();
  endtask

  task automatic test_load;
    logic [4:0] fa_exp;
    logic [4:0] rq_exp;
    fa_exp = 5'b01111;
    rq_exp = 5'b01110;
    @(negedge clk);
    mem_r_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sram_ready = (i == 3);
      #1;
      vecs++;
      if ({freeze_all, sram_req, sram_we} !==
          {fa_exp[i], rq_exp[i], 1'b0}) begin
        errs++;
        $display("FAIL load_cyc%0d: got %b expected %b", i,
                 {freeze_all, sram_req, sram_we},
                 {fa_exp[i], rq_exp[i], 1'b0});
      end
      @(negedge clk);
    end
    clear_inputs();
    #1;
    vecs++;
    if (stall_cnt !== 32'd4) begin
      errs++;
      $display("FAIL load_stall_cnt: got %0d expected 4",
               stall_cnt);
    end
  endtask

  task automatic test_back_to_back;
    logic [5:0] fa_exp;
    logic [5:0] rq_exp;
    fa_exp = 6'b011011;
    rq_exp = 6'b010010;
    @(negedge clk);
    mem_r_en = 1'b1;
    sram_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      vecs++;
      if ({freeze_all, sram_req} !== {fa_exp[i], rq_exp[i]})
      begin
        errs++;
        $display("FAIL b2b_cyc%0d: got %b expected %b", i,
                 {freeze_all, sram_req},
                 {fa_exp[i], rq_exp[i]});
      end
      @(negedge clk);
    end
    clear_inputs();
  endtask

  task automatic test_branch_freeze;
    @(negedge clk);
    mem_r_en = 1'b1;
    exe_branch_taken = 1'b1;
    id_valid = 1'b1; id_src1 = 4'd3;
    exe_wb_en = 1'b1; exe_mem_r_en = 1'b1; exe_dest = 4'd3;
    #1;
    vecs++;
    if ({freeze_all, freeze_fd, flush_fd, bubble_de} !==
        4'b1000) begin
      errs++;
      $display("FAIL br_idle: got %b expected 1000",
               {freeze_all, freeze_fd, flush_fd, bubble_de});
    end
    @(negedge clk);
    sram_ready = 1'b1;
    #1;
    vecs++;
    if ({freeze_all, freeze_fd, flush_fd, bubble_de} !==
        4'b1000) begin
      errs++;
      $display("FAIL br_access: got %b expected 1000",
               {freeze_all, freeze_fd, flush_fd, bubble_de});
    end
    @(negedge clk);
    sram_ready = 1'b0;
    #1;
    vecs++;
    if ({freeze_all, freeze_fd, flush_fd, bubble_de} !==
        4'b0011) begin
      errs++;
      $display("FAIL br_done: got %b expected 0011",
               {freeze_all, freeze_fd, flush_fd, bubble_de});
    end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_store_timeout;
    int  hi;
    logic rq_exp;
    hi = 0;
    @(negedge clk);
    mem_w_en = 1'b1;
    for (int i = 0; i < 18; i++) begin
      #1;
      rq_exp = (i >= 1) && (i <= 16);
      if (sram_req === 1'b1) hi++;
      vecs++;
      if ({sram_req, sram_we} !== {rq_exp, rq_exp}) begin
        errs++;
        $display("FAIL store_cyc%0d: got %b expected %b", i,
                 {sram_req, sram_we}, {rq_exp, rq_exp});
      end
      if (i == 16) begin
        vecs++;
        if (mem_err !== 1'b0) begin
          errs++;
          $display("FAIL err_early: got %b expected 0",
                   mem_err);
        end
      end
      if (i < 17) @(negedge clk);
    end
    vecs++;
    if ({mem_err, freeze_all} !== 2'b10) begin
      errs++;
      $display("FAIL timeout_done: got %b expected 10",
               {mem_err, freeze_all});
    end
    vecs++;
    if (hi != 16) begin
      errs++;
      $display("FAIL req_len: got %0d expected 16", hi);
    end
    clear_inputs();
    repeat (3) @(negedge clk);
    vecs++;
    if ({mem_err, sram_req} !== 2'b10) begin
      errs++;
      $display("FAIL err_sticky: got %b expected 10",
               {mem_err, sram_req});
    end
    rst = 1'b0;
    #1;
    vecs++;
    if (mem_err !== 1'b0) begin
      errs++;
      $display("FAIL err_clear: got %b expected 0", mem_err);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset_mid_access;
    @(negedge clk);
    mem_r_en = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    vecs++;
    if (sram_req !== 1'b1) begin
      errs++;
      $display("FAIL mid_req: got %b expected 1", sram_req);
    end
    rst = 1'b0;
    mem_r_en = 1'b0;
    #1;
    vecs++;
    if ({sram_req, sram_we, freeze_all} !== 3'b000) begin
      errs++;
      $display("FAIL mid_rst: got %b expected 000",
               {sram_req, sram_we, freeze_all});
    end
    vecs++;
    if (stall_cnt !== 32'd0) begin
      errs++;
      $display("FAIL mid_rst_cnt: got %0d expected 0",
               stall_cnt);
    end
    @(negedge clk);
    rst = 1'b1;
    sram_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vecs++;
      if ({sram_req, freeze_all, mem_err} !== 3'b000 ||
          stall_cnt !== 32'd0) begin
        errs++;
        $display("FAIL post_rst%0d: got %b/%0d expected 000/0",
                 i, {sram_req, freeze_all, mem_err}, stall_cnt);
      end
    end
    clear_inputs();
  endtask

  task automatic test_saturate;
    apply_reset();
    @(negedge clk);
    id_valid = 1'b1; id_src1 = 4'd7;
    exe_wb_en = 1'b1; exe_dest = 4'd7;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      if (k == 6) begin
        vecs++;
        if (nf_stall_cnt !== 3'd6) begin
          errs++;
          $display("FAIL sat_mid: got %0d expected 6",
                   nf_stall_cnt);
        end
      end
    end
    vecs++;
    if (nf_stall_cnt !== 3'd7) begin
      errs++;
      $display("FAIL sat_top: got %0d expected 7",
               nf_stall_cnt);
    end
    vecs++;
    if (stall_cnt !== 32'd0) begin
      errs++;
      $display("FAIL fwd_no_stall: got %0d expected 0",
               stall_cnt);
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_raw_nofwd();
    test_branch_hazard();
    apply_reset();
    test_load();
    test_back_to_back();
    test_branch_freeze();
    test_store_timeout();
    test_reset_mid_access();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule
